// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file, two combinational read ports, one write port.
// Latency: reads are zero-cycle combinational; writes land at the next rising clk edge.
// Backpressure: none; always ready. Upstream stalls arrive as modify_flag=0.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   modify_flag/_address/_data     write port from MEM/WB (writes to index 0 are dropped)
//   read_flag1/2, read_address1/2  read port enables and indices from ID
//   read_data1/2                   read data (0 while rst, flag low, or index 0)
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to a
// read port that addresses the register being written (WB-to-ID distance 0).
// With the macro undefined, such a read sees the old value until the next cycle.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        modify_flag,
  input  logic [4:0]  modify_address,
  input  logic [31:0] modify_data,
  input  logic        read_flag1,
  input  logic [4:0]  read_address1,
  input  logic        read_flag2,
  input  logic [4:0]  read_address2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  logic                         wr_en;
  logic                         byp1;
  logic                         byp2;

  // Index 0 is architecturally zero, so a write aimed at it is dropped here;
  // entry 0 is then only ever loaded by reset.
  assign wr_en = modify_flag && (modify_address != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[modify_address] = modify_data;
    end
  end

  // Reset takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // wr_en already excludes index 0, so a forwarded value never leaks onto x0.
  assign byp1 = wr_en && (read_address1 == modify_address);
  assign byp2 = wr_en && (read_address2 == modify_address);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    read_data1 = '0;
    if (!rst && read_flag1 && (read_address1 != 5'd0)) begin
      read_data1 = byp1 ? modify_data : regs_q[read_address1];
    end
  end

  always_comb begin
    read_data2 = '0;
    if (!rst && read_flag2 && (read_address2 != 5'd0)) begin
      read_data2 = byp2 ? modify_data : regs_q[read_address2];
    end
  end

endmodule
